draw_sprite: RTL and testbench
==============================

DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 SHALL have parameter SIZEX, default 48, sprite width in pixels.
REQ-002 SHALL have parameter SIZEY, default 64, sprite height in pixels.
REQ-003 SHALL have parameter ADDR_WIDTH_X, default 6, column bits of the sprite ROM address.
REQ-004 SHALL have parameter ADDR_WIDTH_Y, default 6, row bits of the sprite ROM address.
REQ-005 SHALL have parameter KEY, default 12'hF0F, transparent colour.
REQ-006 SHALL have port clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port xpos  in  12  sprite left edge, screen pixels.
REQ-009 SHALL have port ypos  in  12  sprite top edge, screen lines.
REQ-010 SHALL have port mirror  in  1  1 = draw horizontally flipped.
REQ-011 SHALL have port enable  in  1  1 = sprite shown.
REQ-012 SHALL have ports hcount_in, vcount_in  in  11 each  incoming pixel coordinates.
REQ-013 SHALL have ports hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  incoming timing.
REQ-014 SHALL have port rgb_in  in  12  background pixel.
REQ-015 SHALL have port rom_addr  out  ADDR_WIDTH_X+ADDR_WIDTH_Y  {row, column} to sprite ROM.
REQ-016 SHALL have port rom_rgb  in  12  sprite ROM data, valid one clk after rom_addr.
REQ-017 SHALL have ports hcount_out, vcount_out (11), hsync_out, hblnk_out, vsync_out, vblnk_out (1)  out  delayed timing.
REQ-018 SHALL have port rgb_out  out  12  composited pixel.
REQ-019 SHALL have port sprite_px  out  1  1 = rgb_out is an opaque sprite pixel.

Function
REQ-020 SHALL detect the rising edge of vblnk_in using a registered copy of vblnk_in; on that cycle it SHALL capture xpos, ypos, mirror and enable into frame registers.
REQ-021 SHALL use only the frame registers for drawing, so a sprite never tears mid-frame.
REQ-022 SHALL treat a pixel as in-box when hcount_in >= x_f, hcount_in < x_f+SIZEX, vcount_in >= y_f, vcount_in < y_f+SIZEY, hblnk_in = 0, vblnk_in = 0 and enable_f = 1, where x_f, y_f and enable_f are the captured frame registers.
REQ-023 SHALL evaluate the sums and comparisons at 13 bits so that positions near 4095 never wrap into a false hit.
REQ-024 SHALL compute dx = hcount_in - x_f and dy = vcount_in - y_f; the column SHALL be SIZEX-1-dx when mirror_f = 1, else dx.
REQ-025 SHALL register rom_addr = {dy[ADDR_WIDTH_Y-1:0], column[ADDR_WIDTH_X-1:0]} at stage 1, together with in-box and all timing signals and rgb_in; rom_addr SHALL be 0 when not in-box.
REQ-026 SHALL delay in-box, timing and rgb_in to stage 2, aligned with rom_rgb.
REQ-027 At stage 3 it SHALL register rgb_out = rom_rgb and sprite_px = 1 when in-box and rom_rgb != KEY; otherwise rgb_out = delayed rgb_in and sprite_px = 0.
REQ-028 SHALL give every output exactly 3 clk of latency from the corresponding inputs, with all outputs mutually aligned.
REQ-029 SHALL force rgb_out to 12'h000 whenever the delayed hblnk or vblnk is 1.
REQ-030 When a vblnk_in rising edge coincides with a position change, it SHALL capture the new value on that cycle.
REQ-031 SHALL ignore input position changes at any other time until the next vblnk_in rising edge.

Reset
REQ-032 While rst = 1 at a clk edge, all outputs, pipeline registers, frame registers and the vblnk edge register SHALL clear to 0.
REQ-033 Because enable_f clears on reset, SHALL draw no sprite after reset until the first vblnk_in rising edge with enable = 1.
REQ-034 Assertion of rst mid-line SHALL flush the pipeline, so for the 3 clk after release the outputs reflect only post-reset inputs or 0.

Verification
REQ-035 Bench SHALL cover: xpos=100, ypos=50, enable=1 latched, ROM pattern = address, pixel (100,50) -> 3 clk later rom_addr was 0, rgb_out=12'h000? no: rgb_out = rom[0], sprite_px=1; pixel (147,50) -> rom_addr 12'h02F; pixel (148,50) -> rgb_out=rgb_in, sprite_px=0.
REQ-036 Bench SHALL cover: mirror=1, same position, pixel (100,50) -> rom_addr 12'h02F; pixel (147,50) -> rom_addr 12'h000.
REQ-037 Bench SHALL cover: ROM word = 12'hF0F inside the box, rgb_in=12'h123 -> rgb_out=12'h123, sprite_px=0.
REQ-038 Bench SHALL cover: xpos changed from 100 to 300 mid-frame -> drawing stays at x=100 until after the next vblnk_in rising edge, then at x=300.
REQ-039 Bench SHALL cover: xpos=4090 -> no sprite_px in columns 0..41 (no wrap), box clipped at the screen edge.
REQ-040 Bench SHALL cover: rst pulsed for 1 clk mid-frame -> all outputs 0 the next cycle; no sprite until the next vblnk_in rising edge.

Source files
------------

// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - sprite compositor: per-frame position latch, ROM lookup, 3-clk aligned pipeline
module draw_sprite #(
  parameter int          SIZEX        = 48,
  parameter int          SIZEY        = 64,
  parameter int          ADDR_WIDTH_X = 6,
  parameter int          ADDR_WIDTH_Y = 6,
  parameter logic [11:0] KEY          = 12'hF0F
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [11:0]                          xpos,
  input  logic [11:0]                          ypos,
  input  logic                                 mirror,
  input  logic                                 enable,
  input  logic [10:0]                          hcount_in,
  input  logic [10:0]                          vcount_in,
  input  logic                                 hsync_in,
  input  logic                                 hblnk_in,
  input  logic                                 vsync_in,
  input  logic                                 vblnk_in,
  input  logic [11:0]                          rgb_in,
  output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] rom_addr,
  input  logic [11:0]                          rom_rgb,
  output logic [10:0]                          hcount_out,
  output logic [10:0]                          vcount_out,
  output logic                                 hsync_out,
  output logic                                 hblnk_out,
  output logic                                 vsync_out,
  output logic                                 vblnk_out,
  output logic [11:0]                          rgb_out,
  output logic                                 sprite_px
);

  localparam int                      AW      = ADDR_WIDTH_X + ADDR_WIDTH_Y;
  localparam int                      TW      = 38;
  localparam logic [12:0]             SX13    = 13'(SIZEX);
  localparam logic [12:0]             SY13    = 13'(SIZEY);
  localparam logic [ADDR_WIDTH_X-1:0] COL_MAX = ADDR_WIDTH_X'(SIZEX - 1);

  logic        r_vblnk_d;
  logic [11:0] r_x_f;
  logic [11:0] r_y_f;
  logic        r_mirror_f;
  logic        r_enable_f;
  logic        w_vblnk_rise;

  assign w_vblnk_rise = vblnk_in & ~r_vblnk_d;

  // Position is sampled once per frame so a sprite never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d  <= 1'b0;
      r_x_f      <= 12'h000;
      r_y_f      <= 12'h000;
      r_mirror_f <= 1'b0;
      r_enable_f <= 1'b0;
    end else begin
      r_vblnk_d <= vblnk_in;
      if (w_vblnk_rise) begin
        r_x_f      <= xpos;
        r_y_f      <= ypos;
        r_mirror_f <= mirror;
        r_enable_f <= enable;
      end
    end
  end

  logic [12:0]             w_h13;
  logic [12:0]             w_v13;
  logic [12:0]             w_x13;
  logic [12:0]             w_y13;
  logic                    w_in_box;
  logic [ADDR_WIDTH_X-1:0] w_dx;
  logic [ADDR_WIDTH_Y-1:0] w_dy;
  logic [ADDR_WIDTH_X-1:0] w_col;
  logic [AW-1:0]           w_addr;

  // 13-bit compare keeps a box near x/y = 4095 from wrapping onto column 0.
  assign w_h13    = {2'b00, hcount_in};
  assign w_v13    = {2'b00, vcount_in};
  assign w_x13    = {1'b0, r_x_f};
  assign w_y13    = {1'b0, r_y_f};
  assign w_in_box = r_enable_f & ~hblnk_in & ~vblnk_in &
                    (w_h13 >= w_x13) & (w_h13 < w_x13 + SX13) &
                    (w_v13 >= w_y13) & (w_v13 < w_y13 + SY13);

  // Only the low address bits of the offsets reach the ROM.
  assign w_dx   = hcount_in[ADDR_WIDTH_X-1:0] - r_x_f[ADDR_WIDTH_X-1:0];
  assign w_dy   = vcount_in[ADDR_WIDTH_Y-1:0] - r_y_f[ADDR_WIDTH_Y-1:0];
  assign w_col  = r_mirror_f ? (COL_MAX - w_dx) : w_dx;
  assign w_addr = w_in_box ? {w_dy, w_col} : '0;

  logic [TW-1:0] w_tim_in;
  logic [TW-1:0] r_tim1;
  logic [TW-1:0] r_tim2;
  logic          r_in1;
  logic          r_in2;
  logic [AW-1:0] r_addr1;
  logic [25:0]   r_tim3;
  logic [11:0]   r_rgb3;
  logic          r_spx3;
  logic          w_blank2;
  logic          w_opaque;

  assign w_tim_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};
  assign w_blank2 = r_tim2[14] | r_tim2[12];
  assign w_opaque = r_in2 & (rom_rgb != KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr1 <= '0;
      r_in1   <= 1'b0;
      r_tim1  <= '0;
      r_in2   <= 1'b0;
      r_tim2  <= '0;
      r_tim3  <= '0;
      r_rgb3  <= 12'h000;
      r_spx3  <= 1'b0;
    end else begin
      r_addr1 <= w_addr;
      r_in1   <= w_in_box;
      r_tim1  <= w_tim_in;
      r_in2   <= r_in1;
      r_tim2  <= r_tim1;
      r_tim3  <= r_tim2[TW-1:12];
      if (w_blank2) begin
        r_rgb3 <= 12'h000;
        r_spx3 <= 1'b0;
      end else if (w_opaque) begin
        r_rgb3 <= rom_rgb;
        r_spx3 <= 1'b1;
      end else begin
        r_rgb3 <= r_tim2[11:0];
        r_spx3 <= 1'b0;
      end
    end
  end

  assign rom_addr   = r_addr1;
  assign hcount_out = r_tim3[25:15];
  assign vcount_out = r_tim3[14:4];
  assign hsync_out  = r_tim3[3];
  assign hblnk_out  = r_tim3[2];
  assign vsync_out  = r_tim3[1];
  assign vblnk_out  = r_tim3[0];
  assign rgb_out    = r_rgb3;
  assign sprite_px  = r_spx3;

endmodule

// File: tb/tb_draw_sprite.sv
// tb/tb_draw_sprite.sv - table, directed and random checks of draw_sprite against a frame-level model
module tb_draw_sprite;

  localparam int          SIZEX = 48;
  localparam int          SIZEY = 64;
  localparam logic [11:0] KEY   = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mirror, enable;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        sprite_px;

  draw_sprite dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .mirror(mirror), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in), .rom_addr(rom_addr),
    .rom_rgb(rom_rgb), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out), .sprite_px(sprite_px)
  );

  always #5 clk = ~clk;

  // Sprite ROM whose every word equals its own address, one clk read latency.
  always @(posedge clk) rom_rgb <= rom_addr;

  typedef struct packed {
    logic [11:0] addr;
    logic [38:0] o;
  } exp_t;

  typedef struct {
    int          x, y;
    bit          mir, en;
    int          h, v;
    bit          hb;
    logic [11:0] rin, ea, ergb;
    bit          espx;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   m_x = 0, m_y = 0;
  bit   m_mir = 0, m_en = 0, m_vprev = 0;
  exp_t pend [3] = '{default: '0};
  int   cur_x = -1, cur_y = -1;
  bit   cur_mir = 0, cur_en = 0;
  vec_t vq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [38:0] out_vec();
    return {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out, sprite_px};
  endfunction

  function automatic exp_t model_px();
    exp_t        e;
    int          h, v, dx, dy, col;
    bit          inb;
    logic [11:0] rgb;
    logic        spx;
    h   = int'(hcount_in);
    v   = int'(vcount_in);
    inb = m_en && !hblnk_in && !vblnk_in && h >= m_x && h < m_x + SIZEX && v >= m_y && v < m_y + SIZEY;
    dx  = h - m_x;
    dy  = v - m_y;
    col = m_mir ? SIZEX - 1 - dx : dx;
    e.addr = inb ? 12'((dy % 64) * 64 + (col % 64)) : 12'h000;
    spx = 1'b0;
    if (hblnk_in || vblnk_in) rgb = 12'h000;
    else if (inb && e.addr != KEY) begin
      rgb = e.addr;
      spx = 1'b1;
    end else rgb = rgb_in;
    e.o = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb, spx};
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model_px();
    if (rst) begin
      e       = '0;
      pend[0] = '0;
      pend[1] = '0;
      m_x = 0; m_y = 0; m_mir = 0; m_en = 0; m_vprev = 0;
    end else begin
      if (vblnk_in && !m_vprev) begin
        m_x = int'(xpos); m_y = int'(ypos); m_mir = mirror; m_en = enable;
      end
      m_vprev = vblnk_in;
    end
    @(posedge clk); #1;
    pend[2] = pend[1];
    pend[1] = pend[0];
    pend[0] = e;
    chk("rom_addr", 64'(rom_addr), 64'(pend[0].addr));
    chk("pipe_out", 64'(out_vec()), 64'(pend[2].o));
  endtask

  task automatic drive_px(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rin);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rin;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic set_frame(input int x, input int y, input bit mir, input bit en);
    drive_px(0, 0, 0, 0, 12'h000); tick();
    xpos = 12'(x); ypos = 12'(y); mirror = mir; enable = en;
    drive_px(0, 0, 0, 1, 12'h000); tick();
    drive_px(0, 0, 0, 0, 12'h000); tick();
    cur_x = x; cur_y = y; cur_mir = mir; cur_en = en;
  endtask

  task automatic probe(input string name, input int h, input int v, input bit hb, input logic [11:0] rin,
                       input logic [11:0] ea, input logic [11:0] ergb, input bit espx);
    drive_px(h, v, hb, 0, rin); tick();
    chk({name, "_addr"}, 64'(rom_addr), 64'(ea));
    drive_px(0, 0, 0, 0, 12'h000); tick(); tick();
    chk({name, "_rgb"}, 64'(rgb_out), 64'(ergb));
    chk({name, "_spx"}, 64'(sprite_px), 64'(espx));
  endtask

  task automatic add(input int x, input int y, input bit mir, input bit en, input int h, input int v,
                     input bit hb, input logic [11:0] rin, input logic [11:0] ea, input logic [11:0] ergb,
                     input bit espx);
    vec_t t;
    t.x = x; t.y = y; t.mir = mir; t.en = en; t.h = h; t.v = v; t.hb = hb;
    t.rin = rin; t.ea = ea; t.ergb = ergb; t.espx = espx;
    vq.push_back(t);
  endtask

  initial begin
    int h, v, nx;
    bit vb_state;
    //   x     y  mir en  h     v    hb  rgb_in   addr     rgb      spx
    add(100,  50, 0, 1, 100,   50,  0, 12'h555, 12'h000, 12'h000, 1);
    add(100,  50, 0, 1, 147,   50,  0, 12'h555, 12'h02F, 12'h02F, 1);
    add(100,  50, 0, 1, 148,   50,  0, 12'h555, 12'h000, 12'h555, 0);
    add(100,  50, 0, 1,  99,   50,  0, 12'h321, 12'h000, 12'h321, 0);
    add(100,  50, 0, 1, 100,  113,  0, 12'h555, 12'hFC0, 12'hFC0, 1);
    add(100,  50, 0, 1, 100,  114,  0, 12'h555, 12'h000, 12'h555, 0);
    add(100,  50, 0, 1, 115,  110,  0, 12'h123, 12'hF0F, 12'h123, 0);
    add(100,  50, 0, 1, 120,   60,  1, 12'h777, 12'h000, 12'h000, 0);
    add(100,  50, 1, 1, 100,   50,  0, 12'h555, 12'h02F, 12'h02F, 1);
    add(100,  50, 1, 1, 147,   50,  0, 12'h555, 12'h000, 12'h000, 1);
    add(100,  50, 1, 1, 110,   51,  0, 12'h555, 12'h065, 12'h065, 1);
    add(100,  50, 0, 0, 100,   50,  0, 12'h456, 12'h000, 12'h456, 0);
    add(4090,  0, 0, 1,   0,   10,  0, 12'hABC, 12'h000, 12'hABC, 0);
    add(4090,  0, 0, 1,  41,   10,  0, 12'hABC, 12'h000, 12'hABC, 0);
    add(2040,  0, 0, 1, 2047,  10,  0, 12'hABC, 12'h287, 12'h287, 1);
    add(2040,  0, 0, 1, 2039,  10,  0, 12'hABC, 12'h000, 12'hABC, 0);

    rst = 1'b1; xpos = 12'd0; ypos = 12'd0; mirror = 1'b0; enable = 1'b0;
    drive_px(5, 7, 0, 0, 12'hABC);
    repeat (3) tick();
    chk("reset_out", 64'(out_vec()), 64'd0);
    chk("reset_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    xpos = 12'd0; ypos = 12'd0; enable = 1'b1;
    probe("pre_vblnk", 10, 10, 0, 12'h3C3, 12'h000, 12'h3C3, 0);

    foreach (vq[i]) begin
      if (vq[i].x != cur_x || vq[i].y != cur_y || vq[i].mir != cur_mir || vq[i].en != cur_en)
        set_frame(vq[i].x, vq[i].y, vq[i].mir, vq[i].en);
      probe($sformatf("vec%0d", i), vq[i].h, vq[i].v, vq[i].hb, vq[i].rin, vq[i].ea, vq[i].ergb, vq[i].espx);
    end

    set_frame(100, 50, 0, 1);
    xpos = 12'd300;
    probe("midframe_new", 300, 50, 0, 12'h111, 12'h000, 12'h111, 0);
    probe("midframe_old", 100, 50, 0, 12'h111, 12'h000, 12'h000, 1);
    set_frame(300, 50, 0, 1);
    probe("nextframe_new", 300, 50, 0, 12'h111, 12'h000, 12'h000, 1);
    probe("nextframe_old", 100, 50, 0, 12'h111, 12'h000, 12'h111, 0);

    set_frame(100, 50, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive_px(101 + i, 50, 0, 0, 12'h999); tick();
    end
    rst = 1'b1;
    drive_px(105, 50, 0, 0, 12'h999); tick();
    rst = 1'b0;
    chk("rst_pulse_out", 64'(out_vec()), 64'd0);
    chk("rst_pulse_addr", 64'(rom_addr), 64'd0);
    probe("post_rst", 100, 50, 0, 12'h246, 12'h000, 12'h246, 0);
    set_frame(100, 50, 0, 1);
    probe("post_rst_vbl", 100, 50, 0, 12'h246, 12'h000, 12'h000, 1);

    vb_state = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        xpos   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(3990, 4095)) : 12'($urandom_range(0, 2060));
        ypos   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(3990, 4095)) : 12'($urandom_range(0, 2060));
        mirror = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 39) == 0) vb_state = ~vb_state;
      nx = m_x - 4 + int'($urandom_range(0, 56));
      h  = ($urandom_range(0, 3) == 0 || nx < 0 || nx > 2047) ? int'($urandom_range(0, 2047)) : nx;
      nx = m_y - 4 + int'($urandom_range(0, 72));
      v  = ($urandom_range(0, 3) == 0 || nx < 0 || nx > 2047) ? int'($urandom_range(0, 2047)) : nx;
      rst = ($urandom_range(0, 599) == 0);
      drive_px(h, v, ($urandom_range(0, 15) == 0), vb_state, 12'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
